// File: rtl/adxl362_controller.sv
// Sequences one ADXL362 register read/write into the three-byte SPI frame
// (command, address, data/dummy) on top of a byte-level spi controller.
module adxl362_controller #(
   parameter logic [7:0] CMD_WRITE  = 8'h0A,
   parameter logic [7:0] CMD_READ   = 8'h0B,
   parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       write,
   input  logic [7:0] address,
   input  logic [7:0] data_to_send,
   output logic [7:0] data_received,
   output logic       busy,
   output logic       done,
   output logic       spi_start,
   output logic [7:0] spi_data_to_send,
   output logic       spi_hold_cs,
   input  logic       spi_busy,
   input  logic       spi_done,
   input  logic [7:0] spi_data_received
);

   typedef enum logic [2:0] {
      IDLE, CMD_ST, CMD_WT, ADDR_ST, ADDR_WT, DATA_ST, DATA_WT, DONE
   } state_t;

   state_t     state_reg;
   logic       write_reg;
   logic [7:0] address_reg;
   logic [7:0] wdata_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         write_reg        <= 1'b0;
         address_reg      <= 8'h00;
         wdata_reg        <= 8'h00;
         data_received    <= 8'h00;
         busy             <= 1'b0;
         done             <= 1'b0;
         spi_start        <= 1'b0;
         spi_data_to_send <= 8'h00;
         spi_hold_cs      <= 1'b0;
      end else begin
         spi_start <= 1'b0;
         done      <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  write_reg        <= write;
                  address_reg      <= address;
                  wdata_reg        <= data_to_send;
                  spi_data_to_send <= write ? CMD_WRITE : CMD_READ;
                  spi_hold_cs      <= 1'b1;
                  busy             <= 1'b1;
                  state_reg        <= CMD_ST;
               end
            end
            CMD_ST: begin
               if (!spi_busy) begin
                  spi_start <= 1'b1;
                  state_reg <= CMD_WT;
               end
            end
            CMD_WT: begin
               if (spi_done) begin
                  spi_data_to_send <= address_reg;
                  spi_hold_cs      <= 1'b1;
                  state_reg        <= ADDR_ST;
               end
            end
            ADDR_ST: begin
               if (!spi_busy) begin
                  spi_start <= 1'b1;
                  state_reg <= ADDR_WT;
               end
            end
            ADDR_WT: begin
               // Last byte drops hold so CS releases once it has shifted out.
               if (spi_done) begin
                  spi_data_to_send <= write_reg ? wdata_reg : DUMMY_BYTE;
                  spi_hold_cs      <= 1'b0;
                  state_reg        <= DATA_ST;
               end
            end
            DATA_ST: begin
               if (!spi_busy) begin
                  spi_start <= 1'b1;
                  state_reg <= DATA_WT;
               end
            end
            DATA_WT: begin
               if (spi_done) begin
                  if (!write_reg) begin
                     data_received <= spi_data_received;
                  end
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
